// File: rtl/fir_pkg.sv
// Shared constants and arithmetic helpers for the FIR datapath and its output stage.
package fir_pkg;

    localparam int unsigned IN_W   = 16;
    localparam int unsigned COEF_W = 8;

    typedef struct packed {
        logic        sat;
        logic [31:0] val;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    // Round half toward +inf, arithmetic shift, then clip to a signed out_w-bit range.
    function automatic sat_res_t sat_round(input logic signed [31:0] acc,
                                           input int unsigned rshift,
                                           input int unsigned out_w);
        logic signed [32:0] ext;
        logic signed [32:0] rnd;
        logic signed [32:0] r;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sat_res_t           res;
        ext = {acc[31], acc};
        rnd = '0;
        if (rshift != 0) begin
            rnd = 33'sd1 <<< (rshift - 1);
        end
        r   = (ext + rnd) >>> rshift;
        hi  = (33'sd1 <<< (out_w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (out_w - 1));
        res.sat = 1'b0;
        res.val = 32'(r);
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = 32'(hi);
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = 32'(lo);
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a registered head word and occupancy.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                                  Clk,
    input  logic                                  Rst,
    input  logic                                  wr_en,
    input  logic [WIDTH-1:0]                      wr_data,
    input  logic                                  rd_en,
    output logic [WIDTH-1:0]                      rd_data,
    output logic                                  empty,
    output logic                                  full,
    output logic [fir_pkg::clog2(DEPTH):0]        level
);
    import fir_pkg::*;

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [LW-1:0]    level_nxt;
    logic [LW-1:0]    after_pop;
    logic             push;
    logic             pop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        pop        = rd_en && !empty;
        push       = wr_en && (!full || pop);
        rd_ptr_nxt = rd_ptr + AW'(pop);
        after_pop  = level - LW'(pop);
        level_nxt  = after_pop + LW'(push);
    end

    always_ff @(posedge Clk) begin
        if (!Rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head register: bypass the incoming word when it lands in an otherwise empty FIFO.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            rd_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            empty  <= (level_nxt == '0);
            full   <= (level_nxt == LW'(DEPTH));
            if (level_nxt != '0) begin
                rd_data <= (after_pop == '0) ? wr_data : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: block-sum decimation, rounding/saturation, and an overflow-flagged FWFT FIFO.
module fir_decim_out #(
    parameter int unsigned IN_W       = fir_pkg::IN_W,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned RSHIFT     = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                   Clk,
    input  logic                                   Rst,
    input  logic signed [IN_W-1:0]                 Yin,
    input  logic                                   Yin_valid,
    output logic signed [OUT_W-1:0]                Dout,
    output logic                                   Dout_valid,
    input  logic                                   Dout_ready,
    output logic                                   Sat,
    output logic                                   Ovf,
    input  logic                                   Clr_ovf,
    output logic [fir_pkg::clog2(FIFO_DEPTH):0]    Fifo_level
);
    import fir_pkg::*;

    localparam int unsigned PH_W  = clog2(DECIM);
    localparam int unsigned ACC_W = IN_W + PH_W;

    logic [PH_W-1:0]         phase;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] dump_reg;
    logic                    dump_valid;
    logic signed [ACC_W-1:0] yin_ext;
    logic                    last_phase;
    sat_res_t                sr;
    logic [OUT_W-1:0]        res_val;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    logic                    drop;
    logic                    unused_sr_hi;

    always_comb begin
        yin_ext    = ACC_W'(Yin);
        last_phase = (phase == PH_W'(DECIM - 1));
    end

    // Group accumulation; invalid cycles freeze both phase and partial sum.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            phase      <= '0;
            acc        <= '0;
            dump_reg   <= '0;
            dump_valid <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            if (Yin_valid) begin
                acc <= (phase == '0) ? yin_ext : acc + yin_ext;
                if (last_phase) begin
                    phase      <= '0;
                    dump_reg   <= acc + yin_ext;
                    dump_valid <= 1'b1;
                end else begin
                    phase <= phase + PH_W'(1);
                end
            end
        end
    end

    assign sr           = sat_round(32'(dump_reg), RSHIFT, OUT_W);
    assign res_val      = sr.val[OUT_W-1:0];
    assign unused_sr_hi = ^sr.val[31:OUT_W];

    sync_fifo_fwft #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en   (dump_valid),
        .wr_data (res_val),
        .rd_en   (Dout_ready),
        .rd_data (Dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (Fifo_level)
    );

    assign Dout_valid = !fifo_empty;

    always_comb begin
        pop  = Dout_ready && !fifo_empty;
        drop = dump_valid && fifo_full && !pop;
    end

    // Sat reports clipping even for a dropped result; a drop outranks a clear.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Sat <= 1'b0;
            Ovf <= 1'b0;
        end else begin
            Sat <= dump_valid && sr.sat;
            if (drop) begin
                Ovf <= 1'b1;
            end else if (Clr_ovf) begin
                Ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_decim_out.sv
// Scoreboard bench for fir_decim_out at default parameters (DECIM=4, RSHIFT=2, OUT_W=8, depth 8).
module tb_fir_decim_out;

    logic              Clk = 1'b0;
    logic              Rst;
    logic signed [15:0] Yin;
    logic              Yin_valid;
    logic signed [7:0] Dout;
    logic              Dout_valid;
    logic              Dout_ready;
    logic              Sat;
    logic              Ovf;
    logic              Clr_ovf;
    logic [3:0]        Fifo_level;

    always #5 Clk = ~Clk;

    fir_decim_out dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Yin        (Yin),
        .Yin_valid  (Yin_valid),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .Dout_ready (Dout_ready),
        .Sat        (Sat),
        .Ovf        (Ovf),
        .Clr_ovf    (Clr_ovf),
        .Fifo_level (Fifo_level)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state
    int m_q[$];
    int m_phase;
    int m_acc;
    bit m_pend;
    int m_pend_val;
    bit m_pend_sat;
    bit m_sat;
    bit m_ovf;

    task automatic check_eq(input string tag, input logic signed [31:0] act,
                            input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_result(input int s, output bit sat);
        int r;
        r   = (s + 2) >>> 2;
        sat = 1'b0;
        if (r > 127) begin
            r = 127;
            sat = 1'b1;
        end else if (r < -128) begin
            r = -128;
            sat = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_acc   = 0;
        m_pend  = 1'b0;
        m_pend_val = 0;
        m_pend_sat = 1'b0;
        m_sat   = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Check current outputs, drive one cycle of inputs, then advance the reference.
    task automatic tick(input int y, input bit v, input bit rdy, input bit clr, input bit rst);
        bit pop;
        bit full;
        bit drop;
        check_eq("dout_valid", 32'(Dout_valid), (m_q.size() != 0) ? 1 : 0);
        check_eq("fifo_level", 32'(Fifo_level), m_q.size());
        check_eq("sat", 32'(Sat), 32'(m_sat));
        check_eq("ovf", 32'(Ovf), 32'(m_ovf));
        if (rdy && !rst && m_q.size() != 0) begin
            check_eq("dout", 32'(Dout), m_q[0]);
        end
        Yin        = 16'(y);
        Yin_valid  = v;
        Dout_ready = rdy;
        Clr_ovf    = clr;
        Rst        = rst;
        @(posedge Clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            pop  = rdy && (m_q.size() != 0);
            full = (m_q.size() == 8);
            drop = 1'b0;
            m_sat = m_pend && m_pend_sat;
            if (pop) m_q.delete(0);
            if (m_pend) begin
                if (!full || pop) m_q.push_back(m_pend_val);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_pend = 1'b0;
            if (v) begin
                m_acc = (m_phase == 0) ? y : m_acc + y;
                if (m_phase == 3) begin
                    m_pend_val = exp_result(m_acc, m_pend_sat);
                    m_pend  = 1'b1;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    task automatic feed(input int y, input bit rdy);
        tick(y, 1'b1, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        Rst = 1'b1; Yin = '0; Yin_valid = 1'b0; Dout_ready = 1'b0; Clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_eq("reset_dout", 32'(Dout), 0);
        check_eq("reset_valid", 32'(Dout_valid), 0);
        check_eq("reset_level", 32'(Fifo_level), 0);
        check_eq("reset_ovf", 32'(Ovf), 0);
        check_eq("reset_sat", 32'(Sat), 0);
        tick(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Block average 100/4
        feed(10, 1); feed(20, 1); feed(30, 1); feed(40, 1);
        idle(4, 1);
        // Negative rounding toward +inf
        feed(-3, 1); feed(-3, 1); feed(-3, 1); feed(-2, 1);
        idle(4, 1);
        // Positive and negative clipping
        repeat (4) feed(200, 1);
        idle(3, 1);
        repeat (4) feed(-1000, 1);
        idle(4, 1);
        // Invalid cycles inside a group
        feed(10, 1); tick(999, 1'b0, 1'b1, 1'b0, 1'b0); feed(20, 1);
        tick(-777, 1'b0, 1'b1, 1'b0, 1'b0); feed(30, 1); feed(40, 1);
        idle(4, 1);

        // Overflow: nine groups into an eight-deep FIFO with the sink stalled
        repeat (36) feed(4, 0);
        idle(3, 0);
        check_eq("ovf_level", 32'(Fifo_level), 8);
        check_eq("ovf_flag", 32'(Ovf), 1);
        tick(0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 0);
        idle(12, 1);

        // Reset in the middle of a group discards the partial sum
        feed(50, 1); feed(50, 1);
        tick(0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) feed(8, 1);
        idle(4, 1);

        // Full FIFO with a simultaneous pop accepts the push
        repeat (32) feed(6, 0);
        idle(2, 0);
        feed(-20, 0); feed(-20, 0); feed(-20, 0); feed(-20, 0);
        tick(0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 0);
        check_eq("fullpop_level", 32'(Fifo_level), 8);
        check_eq("fullpop_ovf", 32'(Ovf), 0);
        idle(12, 1);

        // Random traffic with stalls, gaps and clears
        for (int i = 0; i < 400; i++) begin
            tick(int'($urandom_range(0, 60000)) - 30000,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0,
                 1'b0);
        end
        idle(16, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Output stage directly downstream of the 4-tap FIR. It consumes the FIR's 16-bit signed result stream, which arrives one sample per clock with no backpressure.
- Decimates by DECIM by summing DECIM consecutive samples, then scales with rounding and saturates to OUT_W bits.
- Buffers results in a small first-word-fall-through (FWFT) FIFO presented on a valid/ready interface to the sink (DAC packer or host reader).
- Overflow is flagged, never stalled, because the FIR cannot be held off.

Parameters:
- IN_W, 16, input sample width; matches FIR Yout.
- OUT_W, 8, output sample width.
- DECIM, 4, decimation factor; power of 2, range 2..16.
- RSHIFT, 2, arithmetic right shift applied to the sum. Default = log2(DECIM), so the result is the block average.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, at least 2.

Ports:
- Clk, in, 1, rising-edge clock.
- Rst, in, 1, synchronous active-high reset.
- Yin, in, IN_W signed, FIR output sample.
- Yin_valid, in, 1, Yin qualifier; tie high when driven by fir_4tap.
- Dout, out, OUT_W signed, FIFO head sample.
- Dout_valid, out, 1, FIFO non-empty.
- Dout_ready, in, 1, sink accepts Dout this cycle.
- Sat, out, 1, one-cycle pulse: the result just produced was clipped.
- Ovf, out, 1, sticky: a result was dropped because the FIFO was full.
- Clr_ovf, in, 1, clears Ovf.
- Fifo_level, out, clog2(FIFO_DEPTH)+1, occupied entries.

Behaviour:
- Interface: one clock, Clk. Reset Rst is synchronous and active-high. All state updates occur on the rising edge of Clk.
- Reset values: Dout=0, Dout_valid=0, Sat=0, Ovf=0, Fifo_level=0, phase=0, acc=0, dump_valid=0. The FIFO is emptied.
- Reset mid-operation discards any partial sum, any in-flight result, and all FIFO contents. The next valid sample after reset is phase 0.
- Phase counter (0..DECIM-1):
  - Advances only on Yin_valid and wraps DECIM-1 -> 0.
  - Yin_valid=0 holds both phase and acc; gaps do not break a group.
- Accumulator, ACC_W = IN_W + log2(DECIM), signed, cannot overflow:
  - On a valid sample at phase 0: acc <= sext(Yin).
  - On a valid sample at other phases: acc <= acc + sext(Yin).
- Dump: at the edge that accepts the phase DECIM-1 sample (edge k), dump_reg <= acc + sext(Yin) and dump_valid <= 1 for one cycle.
- Scaling, computed from dump_reg:
  - r = (dump_reg + 2^(RSHIFT-1)) >>> RSHIFT, i.e. round half toward +inf with an arithmetic shift (floor).
  - RSHIFT=0 means no rounding term and no shift.
  - The rounding add uses ACC_W+1 bits.
- Saturation:
  - r > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1.
  - r < -2^(OUT_W-1) -> -2^(OUT_W-1).
  - Sat=1 in the cycle after edge k+1 when clipping occurred, whether or not the result is dropped.
- Push: at edge k+1 the saturated result is written to the FIFO.
  - If the FIFO is full and no pop happens that cycle, the result is dropped and Ovf <= 1.
  - If the FIFO is full and a pop happens in the same cycle, the push succeeds and the level is unchanged.
- Latency: with an empty FIFO, Dout_valid=1 and Dout=result in the cycle after edge k+1, i.e. 2 cycles after the last sample of the group.
- Pop: occurs when Dout_valid && Dout_ready. Dout shows the next entry in the following cycle. Dout_ready while empty has no effect.
- Dout holds its last value when the FIFO is empty. It is not required to be zero, except after reset.
- Ovf priority: Ovf clears on Clr_ovf unless a drop occurs in the same cycle, in which case set wins.
- Fifo_level:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Range 0..FIFO_DEPTH.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Package fir_pkg holds:
  - IN_W=16 and COEF_W=8 constants, shared with fir_4tap.
  - Function sat_round(acc, RSHIFT, OUT_W).
  - Function clog2.
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH). Signals:
  - Inputs: Clk, Rst, wr_en, wr_data, rd_en.
  - Outputs: rd_data, empty, full, level.
  - Push when full with a simultaneous read is allowed.
- The top level contains the phase counter, accumulator, dump register, scaling/saturation, and the Ovf/Sat logic.

Test Plan (defaults DECIM=4, RSHIFT=2, OUT_W=8, FIFO_DEPTH=8):
- Yin=10,20,30,40 with Yin_valid=1 and Dout_ready=1 -> sum 100 -> Dout=25 with Dout_valid first high 2 cycles after the sample 40 edge; Sat=0.
- Negative rounding: Yin=-3,-3,-3,-2 -> sum -11 -> (-11+2)>>>2 = -3 -> Dout=-3.
- Saturation: 4x Yin=200 -> Dout=127 and Sat pulses for 1 cycle. Then 4x Yin=-1000 -> Dout=-128 and Sat pulses.
- Valid gaps: Yin 10,(invalid 999),20,(invalid),30,40 -> Dout=25; invalid samples are ignored and phase holds.
- Overflow: Dout_ready=0, 9 groups of 4x Yin=4 -> Fifo_level=8, Dout_valid=1, 9th result dropped, Ovf=1. Pulse Clr_ovf -> Ovf=0. Drain with Dout_ready=1 -> 8 outputs of 4, then Dout_valid=0.
- Mid-group reset and full-with-pop:
  - Feed 2 samples, assert Rst 1 cycle, then 4x Yin=8 -> Dout=8; the pre-reset partial sum is gone.
  - With the FIFO full, hold Dout_ready=1 while a group completes -> push accepted, Fifo_level stays 8, Ovf=0.
